// File: rtl/systolic_job_ctrl.sv
// Wishbone sequencer for the 2x2 int8 systolic array: operand registers, start/wait/capture FSM,
// run-cycle counter and timeout. Optional irq_o output enabled by SYSTOLIC_JOB_IRQ_EN.
module systolic_job_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
`ifdef SYSTOLIC_JOB_IRQ_EN
  output logic        irq_o,
`endif
  output logic [7:0]  arr_a11,
  output logic [7:0]  arr_a12,
  output logic [7:0]  arr_a21,
  output logic [7:0]  arr_a22,
  output logic [7:0]  arr_b11,
  output logic [7:0]  arr_b12,
  output logic [7:0]  arr_b21,
  output logic [7:0]  arr_b22,
  output logic        arr_start,
  input  logic        arr_done,
  input  logic [15:0] arr_c11,
  input  logic [15:0] arr_c12,
  input  logic [15:0] arr_c21,
  input  logic [15:0] arr_c22
);

  typedef enum logic [1:0] {StIdle = 2'd0, StStart = 2'd1, StWait = 2'd2, StCapture = 2'd3} state_e;

  state_e           state_q;
  logic [31:0]      a_q, b_q, res0_q, res1_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             done_q, timeout_q, wr_err_q;
  logic             accept, wr, busy, start_req, clear_req, a_wr, b_wr, irq_bit;
  logic [7:0]       adr;
  logic [31:0]      status, rd_data;
  logic             unused_adr;

  assign unused_adr = ^wbs_adr_i[31:8];
  assign adr        = wbs_adr_i[7:0];

  // Ack gates re-accept so a held strobe never gets back-to-back acks.
  assign accept    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr        = accept & wbs_we_i;
  assign busy      = (state_q != StIdle);
  assign start_req = wr && (adr == 8'h08) && wbs_dat_i[0];
  assign clear_req = wr && (adr == 8'h08) && wbs_dat_i[1];
  assign a_wr      = wr && (adr == 8'h00);
  assign b_wr      = wr && (adr == 8'h04);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef SYSTOLIC_JOB_IRQ_EN
  assign irq_o   = done_q | timeout_q;
  assign irq_bit = irq_o;
`else
  assign irq_bit = 1'b0;
`endif

  assign status = {23'd0, irq_bit, 2'b00, state_q, wr_err_q, timeout_q, done_q, busy};

  always_comb begin
    rd_data = 32'hDEADBEEF;
    case (adr)
      8'h00:   rd_data = a_q;
      8'h04:   rd_data = b_q;
      8'h08:   rd_data = status;
      8'h0C:   rd_data = res0_q;
      8'h10:   rd_data = res1_q;
      8'h14:   rd_data = 32'(cnt_q);
      default: rd_data = 32'hDEADBEEF;
    endcase
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) old[8*i +: 8] = nw[8*i +: 8];
    end
    return old;
  endfunction

  assign {arr_a22, arr_a21, arr_a12, arr_a11} = a_q;
  assign {arr_b22, arr_b21, arr_b12, arr_b11} = b_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
      arr_start <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept;
      if (accept) wbs_dat_o <= rd_data;
      arr_start <= 1'b0;
      // CLEAR lands first; FSM flag updates below take priority in the same cycle.
      if (clear_req) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        wr_err_q  <= 1'b0;
      end
      if (a_wr) begin
        if (busy) wr_err_q <= 1'b1;
        else      a_q      <= merge(a_q, wbs_dat_i, wbs_sel_i);
      end
      if (b_wr) begin
        if (busy) wr_err_q <= 1'b1;
        else      b_q      <= merge(b_q, wbs_dat_i, wbs_sel_i);
      end
      unique case (state_q)
        StIdle: begin
          if (start_req) begin
            state_q   <= StStart;
            arr_start <= 1'b1;
          end
        end
        StStart: begin
          cnt_q     <= '0;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_inc;
          if (arr_done) begin
            state_q <= StCapture;
          end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            state_q   <= StIdle;
            timeout_q <= 1'b1;
          end
        end
        StCapture: begin
          res0_q  <= {arr_c12, arr_c11};
          res1_q  <= {arr_c22, arr_c21};
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_job_ctrl.sv
// Directed bench for systolic_job_ctrl with a small 2x2 array model (fixed 3-cycle latency).
module tb_systolic_job_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  arr_a11, arr_a12, arr_a21, arr_a22, arr_b11, arr_b12, arr_b21, arr_b22;
  logic        arr_start, arr_done;
  logic [15:0] arr_c11, arr_c12, arr_c21, arr_c22;
`ifdef SYSTOLIC_JOB_IRQ_EN
  logic        irq_o;
  localparam logic [31:0] IrqB = 32'h100;
`else
  localparam logic [31:0] IrqB = 32'h0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int starts = 0;
  int tb_cnt = 0;
  logic done_en = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  systolic_job_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
`ifdef SYSTOLIC_JOB_IRQ_EN
    .irq_o    (irq_o),
`endif
    .arr_a11(arr_a11), .arr_a12(arr_a12), .arr_a21(arr_a21), .arr_a22(arr_a22),
    .arr_b11(arr_b11), .arr_b12(arr_b12), .arr_b21(arr_b21), .arr_b22(arr_b22),
    .arr_start(arr_start), .arr_done(arr_done),
    .arr_c11(arr_c11), .arr_c12(arr_c12), .arr_c21(arr_c21), .arr_c22(arr_c22)
  );

  // Array model: C = A x B (int8), done pulses in the third cycle after the start pulse.
  function automatic logic [15:0] mac2(input logic [7:0] x0, input logic [7:0] y0,
                                       input logic [7:0] x1, input logic [7:0] y1);
    logic signed [15:0] p0, p1;
    p0 = $signed({{8{x0[7]}}, x0}) * $signed({{8{y0[7]}}, y0});
    p1 = $signed({{8{x1[7]}}, x1}) * $signed({{8{y1[7]}}, y1});
    return p0 + p1;
  endfunction

  assign arr_c11  = mac2(arr_a11, arr_b11, arr_a12, arr_b21);
  assign arr_c12  = mac2(arr_a11, arr_b12, arr_a12, arr_b22);
  assign arr_c21  = mac2(arr_a21, arr_b11, arr_a22, arr_b21);
  assign arr_c22  = mac2(arr_a21, arr_b12, arr_a22, arr_b22);
  assign arr_done = done_en && (tb_cnt == 3);

  always @(posedge wb_clk_i) begin
    if (arr_start) begin
      tb_cnt <= 1;
      starts <= starts + 1;
    end else if (tb_cnt != 0 && tb_cnt < 1000) begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = {24'h0, adr}; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0;
    rd  = 'x;
    while (lat < 10) begin
      @(posedge wb_clk_i); #1;
      lat++;
      if (wbs_ack_o) break;
    end
    if (!wbs_ack_o) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout adr=%h got no ack within %0d cycles, expected 1", adr, lat);
    end
    rd = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, adr, dat, 4'hF, rd, lat);
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] rd);
    int lat;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat);
  endtask

  task automatic wait_idle(output logic [31:0] st);
    int polls = 0;
    wb_read(8'h08, st);
    while (st[0] && polls < 100) begin
      wb_read(8'h08, st);
      polls++;
    end
    if (st[0]) begin
      n_vec++; n_err++;
      $display("FAIL busy_timeout status=%h still busy, expected idle", st);
    end
  endtask

  task automatic test_reset();
    logic [7:0]  adrs [4] = '{8'h00, 8'h08, 8'h0C, 8'h44};
    logic [31:0] exps [4] = '{32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    logic [31:0] rd; int lat;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    n_vec++;
    if ({arr_start, wbs_ack_o, wbs_dat_o} !== 34'h0) begin
      n_err++; $display("FAIL reset_outputs got %h expected 0", {arr_start, wbs_ack_o, wbs_dat_o});
    end
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, adrs[i], 32'h0, 4'hF, rd, lat);
      n_vec++;
      if (rd !== exps[i]) begin
        n_err++; $display("FAIL reset_read adr=%h got %h expected %h", adrs[i], rd, exps[i]);
      end
      n_vec++;
      if (lat !== 1) begin
        n_err++; $display("FAIL ack_latency adr=%h got %0d expected 1", adrs[i], lat);
      end
    end
  endtask

  task automatic test_job();
    logic [31:0] rd, st;
    int s0;
    done_en = 1'b1;
    wb_write(8'h00, 32'h04030201);
    wb_write(8'h04, 32'h08070605);
    s0 = starts;
    wb_write(8'h08, 32'h1);
    wait_idle(st);
    n_vec++;
    if (st !== (32'h2 | IrqB)) begin
      n_err++; $display("FAIL job_status got %h expected %h", st, 32'h2 | IrqB);
    end
    n_vec++;
    if (starts - s0 !== 1) begin
      n_err++; $display("FAIL job_start_pulses got %0d expected 1", starts - s0);
    end
    wb_read(8'h0C, rd);
    n_vec++;
    if (rd !== 32'h00160013) begin
      n_err++; $display("FAIL job_res0 got %h expected 00160013", rd);
    end
    wb_read(8'h10, rd);
    n_vec++;
    if (rd !== 32'h0032002B) begin
      n_err++; $display("FAIL job_res1 got %h expected 0032002b", rd);
    end
    wb_read(8'h14, rd);
    n_vec++;
    if (rd !== 32'd3) begin
      n_err++; $display("FAIL job_cycles got %0d expected 3", rd);
    end
`ifdef SYSTOLIC_JOB_IRQ_EN
    n_vec++;
    if (irq_o !== 1'b1) begin
      n_err++; $display("FAIL irq_on_done got %b expected 1", irq_o);
    end
    wb_write(8'h08, 32'h2);
    #1;
    n_vec++;
    if (irq_o !== 1'b0) begin
      n_err++; $display("FAIL irq_clear got %b expected 0", irq_o);
    end
`endif
  endtask

  task automatic test_timeout();
    logic [31:0] rd, st;
    done_en = 1'b0;
    wb_write(8'h08, 32'h1);
    wait_idle(st);
    n_vec++;
    if (st !== (32'h4 | IrqB)) begin
      n_err++; $display("FAIL timeout_status got %h expected %h", st, 32'h4 | IrqB);
    end
    wb_read(8'h14, rd);
    n_vec++;
    if (rd !== 32'd64) begin
      n_err++; $display("FAIL timeout_cycles got %0d expected 64", rd);
    end
    wb_read(8'h0C, rd);
    n_vec++;
    if (rd !== 32'h00160013) begin
      n_err++; $display("FAIL timeout_res0_kept got %h expected 00160013", rd);
    end
    wb_read(8'h10, rd);
    n_vec++;
    if (rd !== 32'h0032002B) begin
      n_err++; $display("FAIL timeout_res1_kept got %h expected 0032002b", rd);
    end
  endtask

  task automatic test_busy_write();
    logic [31:0] st;
    int s0;
    done_en = 1'b0;
    s0 = starts;
    wb_write(8'h08, 32'h1);
    wb_write(8'h00, 32'hFFFFFFFF);
    wb_write(8'h08, 32'h1);
    n_vec++;
    if ({arr_a22, arr_a21, arr_a12, arr_a11} !== 32'h04030201) begin
      n_err++; $display("FAIL busy_operands got %h expected 04030201",
                        {arr_a22, arr_a21, arr_a12, arr_a11});
    end
    wb_read(8'h08, st);
    n_vec++;
    if (st !== 32'h29) begin
      n_err++; $display("FAIL busy_status got %h expected 00000029", st);
    end
    wait_idle(st);
    n_vec++;
    if (starts - s0 !== 1) begin
      n_err++; $display("FAIL busy_start_pulses got %0d expected 1", starts - s0);
    end
    wb_write(8'h08, 32'h2);
    wb_read(8'h08, st);
    n_vec++;
    if (st !== 32'h0) begin
      n_err++; $display("FAIL clear_flags got %h expected 0", st);
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, 8'h00, 32'h0000AA00, 4'b0010, rd, lat);
    wb_read(8'h00, rd);
    n_vec++;
    if (rd !== 32'h0403AA01) begin
      n_err++; $display("FAIL partial_write got %h expected 0403aa01", rd);
    end
    n_vec++;
    if (arr_a12 !== 8'hAA) begin
      n_err++; $display("FAIL partial_a12 got %h expected aa", arr_a12);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    done_en = 1'b0;
    wb_write(8'h08, 32'h1);
    repeat (5) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    n_vec++;
    if ({arr_a22, arr_a21, arr_a12, arr_a11, arr_b22, arr_b21, arr_b12, arr_b11,
         arr_start, wbs_ack_o, wbs_dat_o} !== 98'h0) begin
      n_err++; $display("FAIL reset_mid_outputs a=%h b=%h start=%b ack=%b dat=%h expected 0",
                        {arr_a22, arr_a21, arr_a12, arr_a11}, {arr_b22, arr_b21, arr_b12, arr_b11},
                        arr_start, wbs_ack_o, wbs_dat_o);
    end
`ifdef SYSTOLIC_JOB_IRQ_EN
    n_vec++;
    if (irq_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_irq got %b expected 0", irq_o);
    end
`endif
    wb_rst_i = 1'b0;
    wb_read(8'h08, st);
    n_vec++;
    if (st !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_status got %h expected 0", st);
    end
    test_job();
  endtask

  initial begin
    test_reset();
    test_job();
    test_timeout();
    test_busy_write();
    test_partial();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
